// File: rtl/iter_divider_if.sv
// Divide-unit operation type and the pipeline-side request/response bundle.
// The pipeline drives the master side and the divider implements the slave side.
`timescale 1ns/1ps

package iter_divider_pkg;
  typedef enum logic [1:0] {
    divop_div,
    divop_divu,
    divop_rem,
    divop_remu
  } rv32_divop;
endpackage

interface iter_divider_if #(
  parameter int N = 32
);
  import iter_divider_pkg::*;

  logic          i_en;
  rv32_divop     i_divop;
  logic [N-1:0]  i_data_a;
  logic [N-1:0]  i_data_b;
  logic [N-1:0]  o_data;
  logic          o_stall;

  modport master (
    output i_en, i_divop, i_data_a, i_data_b,
    input  o_data, o_stall
  );

  modport slave (
    input  i_en, i_divop, i_data_a, i_data_b,
    output o_data, o_stall
  );
endinterface

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU, S quotient bits per cycle.
// Divide-by-zero and signed overflow bypass the iteration and finish in one cycle.
`timescale 1ns/1ps

module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int N = 32,
  parameter int S = 2
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  iter_divider_if.slave  bus
);

  localparam int K  = N / S;
  localparam int CW = $clog2(K + 1);
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  if (N < 4 || (N & (N - 1)) != 0 || S < 1 || (S & (S - 1)) != 0 || S > N) begin : g_param_err
    $error("iter_divider: N must be a power of 2 >= 4 and S a power of 2 dividing N");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

  state_e         r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_rem, r_quo, r_div, r_data;
  logic           r_op_div, r_neg_q, r_neg_r;
  logic           w_stall, w_start, w_last;

  // Operand decode at request time
  logic           w_op_signed, w_op_div, w_a_neg, w_b_neg, w_div0, w_ovf, w_special;
  logic [N-1:0]   w_abs_a, w_abs_b, w_special_res;

  assign w_op_signed = (bus.i_divop == divop_div) || (bus.i_divop == divop_rem);
  assign w_op_div    = (bus.i_divop == divop_div) || (bus.i_divop == divop_divu);
  assign w_a_neg     = w_op_signed & bus.i_data_a[N-1];
  assign w_b_neg     = w_op_signed & bus.i_data_b[N-1];
  assign w_abs_a     = w_a_neg ? -bus.i_data_a : bus.i_data_a;
  assign w_abs_b     = w_b_neg ? -bus.i_data_b : bus.i_data_b;
  assign w_div0      = (bus.i_data_b == '0);
  assign w_ovf       = w_op_signed && (bus.i_data_a == MIN_NEG) && (bus.i_data_b == '1);
  assign w_special   = w_div0 | w_ovf;
  assign w_special_res = w_div0 ? (w_op_div ? '1 : bus.i_data_a)
                                : (w_op_div ? MIN_NEG : '0);

  // S unrolled restoring steps; bit N of the trial difference is the borrow
  logic [N-1:0] w_rem [S+1];
  logic [N-1:0] w_quo [S+1];
  logic [N-1:0] w_q_fin, w_r_fin;

  assign w_rem[0] = r_rem;
  assign w_quo[0] = r_quo;

  for (genvar g = 0; g < S; g++) begin : g_step
    logic [N:0] w_trial;
    assign w_trial    = {w_rem[g], w_quo[g][N-1]} - {1'b0, r_div};
    assign w_rem[g+1] = w_trial[N] ? {w_rem[g][N-2:0], w_quo[g][N-1]} : w_trial[N-1:0];
    assign w_quo[g+1] = {w_quo[g][N-2:0], ~w_trial[N]};
  end

  assign w_q_fin = r_neg_q ? -w_quo[S] : w_quo[S];
  assign w_r_fin = r_neg_r ? -w_rem[S] : w_rem[S];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_start     = 1'b0;
    w_last      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_stall = bus.i_en & i_rst_n;
        if (bus.i_en) begin
          w_start     = 1'b1;
          w_state_nxt = w_special ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_stall = 1'b1;
        if (r_cnt == CW'(K - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_data   <= '0;
      r_op_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (w_start) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= w_abs_a;
      r_div    <= w_abs_b;
      r_op_div <= w_op_div;
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      if (w_special) r_data <= w_special_res;
    end else if (r_state == ST_BUSY) begin
      r_cnt <= r_cnt + 1'b1;
      r_rem <= w_rem[S];
      r_quo <= w_quo[S];
      if (w_last) r_data <= r_op_div ? w_q_fin : w_r_fin;
    end
  end

  assign bus.o_data  = r_data;
  assign bus.o_stall = w_stall;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed vector table, multi-cycle corner
// sequences, and randomized operations against an arithmetic reference model.
`timescale 1ns/1ps

module tb_iter_divider;
  import iter_divider_pkg::*;

  localparam int N          = 32;
  localparam int STALL_NORM = 17;
  localparam int STALL_SPEC = 1;
  localparam int MAX_WAIT   = 200;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  iter_divider_if #(.N(N)) bus ();

  iter_divider #(.N(N), .S(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference: plain 64-bit arithmetic plus the architectural divide-by-zero rule.
  function automatic logic [31:0] ref_result(input rv32_divop op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb;
    logic [63:0] full;
    if (b == 32'd0)
      return (op == divop_div || op == divop_divu) ? 32'hFFFF_FFFF : a;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      divop_div:  full = 64'(sa / sb);
      divop_rem:  full = 64'(sa % sb);
      divop_divu: full = {32'd0, a / b};
      default:    full = {32'd0, a % b};
    endcase
    return full[31:0];
  endfunction

  function automatic int ref_stall(input rv32_divop op, input logic [31:0] a,
                                   input logic [31:0] b);
    bit is_signed;
    is_signed = (op == divop_div) || (op == divop_rem);
    if (b == 32'd0 || (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
      return STALL_SPEC;
    return STALL_NORM;
  endfunction

  // Counts stalled cycles from the current one until o_stall drops, then samples o_data.
  task automatic wait_done(output logic [31:0] data, output int stall);
    stall = 0;
    #1;
    while (bus.o_stall === 1'b1 && stall < MAX_WAIT) begin
      stall++;
      @(negedge clk);
    end
    data = bus.o_data;
  endtask

  task automatic run_op(input rv32_divop op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] data, output int stall);
    @(negedge clk);
    bus.i_en     = 1'b1;
    bus.i_divop  = op;
    bus.i_data_a = a;
    bus.i_data_b = b;
    wait_done(data, stall);
    bus.i_en = 1'b0;
  endtask

  typedef struct {
    rv32_divop   op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    int          exp_stall;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input rv32_divop op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_data, input int exp_stall, input string name);
    vec_t v;
    v.op = op; v.a = a; v.b = b;
    v.exp_data = exp_data; v.exp_stall = exp_stall; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] data, a, b;
    int          stall, pre, sel;
    rv32_divop   op;

    rst_n        = 1'b0;
    bus.i_en     = 1'b0;
    bus.i_divop  = divop_div;
    bus.i_data_a = '0;
    bus.i_data_b = '0;

    add_vec(divop_divu, 32'd100,        32'd7,          32'd14,         STALL_NORM, "divu 100/7");
    add_vec(divop_remu, 32'd100,        32'd7,          32'd2,          STALL_NORM, "remu 100/7");
    add_vec(divop_div,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  STALL_NORM, "div -7/2");
    add_vec(divop_rem,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  STALL_NORM, "rem -7/2");
    add_vec(divop_div,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  STALL_NORM, "div 7/-2");
    add_vec(divop_rem,  32'd7,          32'hFFFF_FFFE,  32'd1,          STALL_NORM, "rem 7/-2");
    add_vec(divop_div,  32'd5,          32'd0,          32'hFFFF_FFFF,  STALL_SPEC, "div 5/0");
    add_vec(divop_remu, 32'd5,          32'd0,          32'd5,          STALL_SPEC, "remu 5/0");
    add_vec(divop_divu, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  STALL_SPEC, "divu max/0");
    add_vec(divop_rem,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  STALL_SPEC, "rem -7/0");
    add_vec(divop_div,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  STALL_SPEC, "div ovf");
    add_vec(divop_rem,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          STALL_SPEC, "rem ovf");
    add_vec(divop_divu, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          STALL_NORM, "divu max/max");
    add_vec(divop_divu, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          STALL_NORM, "divu min/max");
    add_vec(divop_remu, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  STALL_NORM, "remu min/max");
    add_vec(divop_div,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         STALL_NORM, "div -100/-7");

    #12;
    check("reset o_stall", {31'd0, bus.o_stall}, 32'd0);
    check("reset o_data",  bus.o_data,           32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, data, stall);
      check({vecs[i].name, " data"},  data,         vecs[i].exp_data);
      check({vecs[i].name, " stall"}, 32'(stall),   32'(vecs[i].exp_stall));
    end

    // Result stays on o_data in the following idle cycle.
    @(negedge clk);
    check("held data",  bus.o_data,           32'd14);
    check("idle stall", {31'd0, bus.o_stall}, 32'd0);

    // Request dropped and operands scrambled mid-iteration: operation still completes.
    @(negedge clk);
    bus.i_en = 1'b1; bus.i_divop = divop_divu; bus.i_data_a = 32'd100; bus.i_data_b = 32'd7;
    pre = 0;
    repeat (3) begin
      #1;
      if (bus.o_stall === 1'b1) pre++;
      @(negedge clk);
    end
    bus.i_en = 1'b0; bus.i_divop = divop_rem; bus.i_data_a = 32'd9999; bus.i_data_b = 32'd3;
    wait_done(data, stall);
    check("mid-busy change data",  data,             32'd14);
    check("mid-busy change stall", 32'(pre + stall), 32'(STALL_NORM));

    // Back-to-back with i_en held high across both instructions.
    @(negedge clk);
    bus.i_en = 1'b1; bus.i_divop = divop_divu; bus.i_data_a = 32'd100; bus.i_data_b = 32'd7;
    wait_done(data, stall);
    check("b2b first data",  data,        32'd14);
    check("b2b first stall", 32'(stall),  32'(STALL_NORM));
    bus.i_divop = divop_remu;
    @(negedge clk);
    wait_done(data, stall);
    check("b2b second data",  data,       32'd2);
    check("b2b second stall", 32'(stall), 32'(STALL_NORM));
    bus.i_en = 1'b0;

    // Asynchronous reset in BUSY cycle 5, with the request still held.
    @(negedge clk);
    bus.i_en = 1'b1; bus.i_divop = divop_divu; bus.i_data_a = 32'hFFFF_FFFF; bus.i_data_b = 32'd3;
    repeat (5) @(negedge clk);
    check("pre-reset busy", {31'd0, bus.o_stall}, 32'd1);
    check("pre-reset held", bus.o_data,           32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset stall", {31'd0, bus.o_stall}, 32'd0);
    check("async reset data",  bus.o_data,           32'd0);
    @(negedge clk);
    bus.i_en = 1'b0;
    @(negedge clk);
    check("in-reset data", bus.o_data, 32'd0);
    rst_n = 1'b1;
    run_op(divop_divu, 32'd1000, 32'd10, data, stall);
    check("post-reset data",  data,       32'd100);
    check("post-reset stall", 32'(stall), 32'(STALL_NORM));

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 150; i++) begin
      op  = rv32_divop'($urandom_range(0, 3));
      sel = $urandom_range(0, 7);
      a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
      b   = $urandom;
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin
          b = 32'($urandom_range(1, 15));
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        default: ;
      endcase
      run_op(op, a, b, data, stall);
      check($sformatf("rand %0d data op=%0d a=%08h b=%08h", i, op, a, b), data, ref_result(op, a, b));
      check($sformatf("rand %0d stall", i), 32'(stall), 32'(ref_stall(op, a, b)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
